// File: rtl/axis_frame_fifo.sv
// rtl/axis_frame_fifo.sv - store-and-forward AXI-Stream frame FIFO with bad/oversize frame drop
// Frames become readable only once their tlast beat commits; rejected frames are rewound in place.
module axis_frame_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_DEPTH     = 4,
    parameter bit DROP_BAD_FRAME = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tuser,
    input  logic                  s_tlast,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tuser,
    output logic                  m_tlast,
    output logic [ADDR_DEPTH:0]   frame_count,
    output logic                  good_frame,
    output logic                  bad_frame,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** ADDR_DEPTH;
    localparam int PW    = ADDR_DEPTH + 1;
    localparam int EW    = DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_wr_commit;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_frame_count;
    logic          r_good;
    logic          r_bad;
    logic          r_ovf;

    logic          w_good;
    logic          w_bad;
    logic          w_ovf;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_hs;
    logic          w_rd_hs;
    logic          w_rd_last;
    logic          w_in_frame;
    logic          w_store;
    logic          w_spill;
    logic          w_tuser_bad;
    logic          w_commit;
    logic          w_rewind;
    logic [EW-1:0] w_rd_entry;

    assign w_full      = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
    assign w_empty     = (r_rd_ptr == r_wr_commit);
    // A full buffer with nothing committed can only hold the current frame: accept and spill it.
    assign s_tready    = (r_state == ST_DROP) || !w_full || w_empty;
    assign w_wr_hs     = s_tvalid && s_tready;
    assign w_in_frame  = (r_state != ST_DROP);
    assign w_store     = w_wr_hs && w_in_frame && !w_full;
    assign w_spill     = w_wr_hs && w_in_frame && w_full;
    assign w_tuser_bad = DROP_BAD_FRAME && s_tuser;
    assign w_commit    = w_store && s_tlast && !w_tuser_bad;
    assign w_rewind    = (w_store && s_tlast && w_tuser_bad) || w_spill;

    assign w_rd_entry  = r_mem[r_rd_ptr[ADDR_DEPTH-1:0]];
    assign m_tdata     = w_rd_entry[DATA_WIDTH-1:0];
    assign m_tlast     = w_rd_entry[DATA_WIDTH];
    assign m_tuser     = w_rd_entry[DATA_WIDTH+1];
    assign m_tvalid    = !w_empty;
    assign w_rd_hs     = !w_empty && m_tready;
    assign w_rd_last   = w_rd_hs && m_tlast;

    assign frame_count = r_frame_count;
    assign good_frame  = r_good;
    assign bad_frame   = r_bad;
    assign overflow    = r_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_good  <= 1'b0;
            r_bad   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_good  <= w_good;
            r_bad   <= w_bad;
            r_ovf   <= w_ovf;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_FRAME: begin
                if (w_store) begin
                    w_next_state = s_tlast ? ST_IDLE : ST_FRAME;
                end else if (w_spill) begin
                    w_next_state = s_tlast ? ST_IDLE : ST_DROP;
                end
            end
            ST_DROP: begin
                if (w_wr_hs && s_tlast) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_good = w_commit;
        w_bad  = w_store && s_tlast && w_tuser_bad;
        w_ovf  = 1'b0;
        if (w_wr_hs && s_tlast && ((r_state == ST_DROP) || w_spill)) begin
            w_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_wr_commit   <= '0;
            r_rd_ptr      <= '0;
            r_frame_count <= '0;
        end else begin
            if (w_rewind) begin
                r_wr_ptr <= r_wr_commit;
            end else if (w_store) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_commit) begin
                r_wr_commit <= r_wr_ptr + 1'b1;
            end
            if (w_rd_hs) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_commit, w_rd_last})
                2'b10:   r_frame_count <= r_frame_count + 1'b1;
                2'b01:   r_frame_count <= r_frame_count - 1'b1;
                default: r_frame_count <= r_frame_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr[ADDR_DEPTH-1:0]] <= {s_tuser, s_tlast, s_tdata};
        end
    end

endmodule

// File: tb/tb_axis_frame_fifo.sv
// tb/tb_axis_frame_fifo.sv - randomized scoreboard bench for axis_frame_fifo
module tb_axis_frame_fifo;

    localparam int DW = 8;
    localparam int AD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tuser = 1'b0;
    logic          s_tlast = 1'b0;
    logic          m_tready = 1'b0;
    logic          keep_en = 1'b0;

    logic          s_tready, m_tvalid, m_tuser, m_tlast;
    logic [DW-1:0] m_tdata;
    logic [AD:0]   frame_count;
    logic          good_frame, bad_frame, overflow;

    logic          k_s_tvalid, k_s_tready, k_m_tvalid, k_m_tuser, k_m_tlast;
    logic [DW-1:0] k_m_tdata;
    logic [AD:0]   k_frame_count;
    logic          k_good_frame, k_bad_frame, k_overflow;

    assign k_s_tvalid = s_tvalid & keep_en;

    axis_frame_fifo #(.DATA_WIDTH(DW), .ADDR_DEPTH(AD), .DROP_BAD_FRAME(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tuser(m_tuser), .m_tlast(m_tlast),
        .frame_count(frame_count), .good_frame(good_frame),
        .bad_frame(bad_frame), .overflow(overflow)
    );

    axis_frame_fifo #(.DATA_WIDTH(DW), .ADDR_DEPTH(AD), .DROP_BAD_FRAME(1'b0)) u_keep (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(k_s_tvalid), .s_tready(k_s_tready),
        .s_tuser(s_tuser), .s_tlast(s_tlast),
        .m_tdata(k_m_tdata), .m_tvalid(k_m_tvalid), .m_tready(m_tready),
        .m_tuser(k_m_tuser), .m_tlast(k_m_tlast),
        .frame_count(k_frame_count), .good_frame(k_good_frame),
        .bad_frame(k_bad_frame), .overflow(k_overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    int n_pop0 = 0, n_pop1 = 0, n_good = 0, n_bad = 0, n_ovf = 0, n_mvalid = 0;
    int fc_model = 0, fc_max = 0;
    bit pend_rd = 1'b0;
    logic [9:0] e0, e1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            fc_model = 0;
            pend_rd  = 1'b0;
        end else begin
            if (good_frame) n_good++;
            if (bad_frame) n_bad++;
            if (overflow) n_ovf++;
            if (m_tvalid) n_mvalid++;
            if (pend_rd) fc_model--;
            check("frame_count", 64'(frame_count), 64'(fc_model));
            if (int'(frame_count) > fc_max) fc_max = int'(frame_count);
            pend_rd = m_tvalid && m_tready && m_tlast;
            if (m_tvalid && m_tready) begin
                if (q0.size() == 0) begin
                    flag_fail("unexpected_beat_drop_dut");
                end else begin
                    e0 = q0.pop_front();
                    check("beat_drop_dut", 64'({m_tuser, m_tlast, m_tdata}), 64'(e0));
                    n_pop0++;
                end
            end
            if (k_m_tvalid && m_tready) begin
                if (q1.size() == 0) begin
                    flag_fail("unexpected_beat_keep_dut");
                end else begin
                    e1 = q1.pop_front();
                    check("beat_keep_dut", 64'({k_m_tuser, k_m_tlast, k_m_tdata}), 64'(e1));
                    n_pop1++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic u, input logic l, output int waits);
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (s_tready) begin
                tick(1);
                break;
            end
            tick(1);
            waits++;
            if (waits > 2000) begin
                flag_fail("send_beat_timeout");
                break;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit bad, input bit rnd, input logic [7:0] first,
                              input bit expect_out, output int stalls);
        logic [7:0] d;
        logic       lst;
        logic       u;
        int         w;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            d   = rnd ? 8'($urandom) : first + 8'(i);
            lst = (i == len - 1);
            u   = lst && bad;
            if (expect_out && !bad) q0.push_back({u, lst, d});
            if (keep_en) q1.push_back({u, lst, d});
            if (rnd && $urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            send_beat(d, u, lst, w);
            stalls += w;
        end
        if (expect_out && !bad) fc_model++;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        m_tready = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0 || m_tvalid || k_m_tvalid) && n < 500) begin
            tick(1);
            n++;
        end
        tick(2);
        check({name, "_q_left"}, 64'(q0.size() + q1.size()), 64'd0);
        check({name, "_m_tvalid_idle"}, 64'(m_tvalid), 64'd0);
        check({name, "_frame_count_idle"}, 64'(frame_count), 64'd0);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_s_tready"}, 64'(s_tready), 64'd1);
        check({name, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
        check({name, "_frame_count"}, 64'(frame_count), 64'd0);
        check({name, "_pulses"}, 64'({good_frame, bad_frame, overflow}), 64'd0);
    endtask

    initial begin
        int st, base0, base1, g0, b0;
        bit done;
        tick(3);
        reset = 1'b0;
        check_reset_state("reset");

        // Commit latency: nothing visible until the tlast edge.
        m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            q0.push_back({1'b0, (i == 4), 8'(i + 1)});
            send_beat(8'(i + 1), 1'b0, (i == 4), st);
            if (i == 4) fc_model++;
            check($sformatf("latency_m_tvalid_beat%0d", i + 1), 64'(m_tvalid), (i == 4) ? 64'd1 : 64'd0);
        end
        check("latency_frame_count", 64'(frame_count), 64'd1);
        drain("latency");
        check("latency_good_pulses", 64'(n_good), 64'd1);

        // Bad frame: dropped by one instance, kept with tuser by the other.
        base0 = n_pop0;
        base1 = n_pop1;
        keep_en = 1'b1;
        send_frame(3, 1'b1, 1'b0, 8'h31, 1'b1, st);
        send_frame(2, 1'b0, 1'b0, 8'hA0, 1'b1, st);
        keep_en = 1'b0;
        drain("badframe");
        check("badframe_pulses", 64'(n_bad), 64'd1);
        check("badframe_drop_beats", 64'(n_pop0 - base0), 64'd2);
        check("badframe_keep_beats", 64'(n_pop1 - base1), 64'd5);

        // Oversize frame into an empty buffer with the reader stalled.
        m_tready = 1'b0;
        base0 = n_mvalid;
        send_frame(20, 1'b0, 1'b0, 8'h40, 1'b0, st);
        check("oversize_stalls", 64'(st), 64'd0);
        tick(2);
        check("oversize_pulses", 64'(n_ovf), 64'd1);
        check("oversize_m_tvalid_cycles", 64'(n_mvalid - base0), 64'd0);
        send_frame(4, 1'b0, 1'b0, 8'h50, 1'b1, st);
        drain("oversize_next");

        // Backpressure: four 4-beat frames fill the buffer exactly.
        m_tready = 1'b0;
        b0 = 0;
        for (int f = 0; f < 4; f++) begin
            send_frame(4, 1'b0, 1'b0, 8'(8'h60 + f * 4), 1'b1, st);
            b0 += st;
        end
        check("backpressure_fill_stalls", 64'(b0), 64'd0);
        for (int i = 0; i < 4; i++) q0.push_back({1'b0, (i == 3), 8'(8'h70 + i)});
        s_tdata = 8'h70; s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b1;
        @(negedge clk);
        check("backpressure_s_tready_low", 64'(s_tready), 64'd0);
        tick(1);
        base0 = n_pop0;
        m_tready = 1'b1;
        for (int n = 0; n < 20 && !s_tready; n++) tick(1);
        check("backpressure_drained_before_ready", 64'(n_pop0 - base0), 64'd1);
        for (int i = 0; i < 4; i++) send_beat(8'(8'h70 + i), 1'b0, (i == 3), st);
        fc_model++;
        drain("backpressure");

        // Random frames across pointer wrap with random valid/ready.
        g0 = n_good;
        b0 = n_bad;
        base0 = 0;
        base1 = 0;
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 200; f++) begin
                    bit bad;
                    bad = ($urandom_range(0, 3) == 0);
                    if (bad) base1++; else base0++;
                    send_frame($urandom_range(1, 16), bad, 1'b1, 8'h00, 1'b1, st);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick(1);
                    m_tready = $urandom_range(0, 1) == 1;
                end
            end
        join
        drain("random");
        check("random_good_pulses", 64'(n_good - g0), 64'(base0));
        check("random_bad_pulses", 64'(n_bad - b0), 64'(base1));
        check("random_frame_count_max_le_16", 64'(fc_max <= 16), 64'd1);

        // Reset in the middle of a frame with a committed frame buffered.
        m_tready = 1'b0;
        g0 = n_good;
        send_frame(2, 1'b0, 1'b0, 8'hC0, 1'b1, st);
        for (int i = 0; i < 3; i++) send_beat(8'(8'hD0 + i), 1'b0, 1'b0, st);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        q0.delete();
        fc_model = 0;
        check_reset_state("midreset");
        base0 = n_pop0;
        send_frame(3, 1'b0, 1'b0, 8'hE0, 1'b1, st);
        drain("midreset");
        check("midreset_beats_read", 64'(n_pop0 - base0), 64'd3);
        check("midreset_good_pulses", 64'(n_good - g0), 64'd2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
